// File: rtl/xif_coproc_alu_frontend_if.sv
// XIF issue/commit/result bundle between the core and the ALU coprocessor front end.
// The master side is the core; the slave side is the coprocessor.
interface xif_coproc_alu_frontend_if #(
  parameter int X_ID_WIDTH = 4,
  parameter int X_NUM_RS   = 2
);
  // Issue channel
  logic                     xif_issue_valid;
  logic                     xif_issue_ready;
  logic [31:0]              xif_issue_instr;
  logic [X_ID_WIDTH-1:0]    xif_issue_id;
  logic [X_NUM_RS*32-1:0]   xif_issue_rs;
  logic [X_NUM_RS-1:0]      xif_issue_rs_valid;
  logic                     xif_issue_accept;
  logic                     xif_issue_writeback;
  // Commit channel
  logic                     xif_commit_valid;
  logic [X_ID_WIDTH-1:0]    xif_commit_id;
  logic                     xif_commit_kill;
  // Result channel
  logic                     xif_result_valid;
  logic                     xif_result_ready;
  logic [X_ID_WIDTH-1:0]    xif_result_id;
  logic [31:0]              xif_result_data;
  logic [4:0]               xif_result_rd;
  logic                     xif_result_we;

  modport master (
    output xif_issue_valid, xif_issue_instr, xif_issue_id, xif_issue_rs, xif_issue_rs_valid,
    input  xif_issue_ready, xif_issue_accept, xif_issue_writeback,
    output xif_commit_valid, xif_commit_id, xif_commit_kill,
    input  xif_result_valid, xif_result_id, xif_result_data, xif_result_rd, xif_result_we,
    output xif_result_ready
  );

  modport slave (
    input  xif_issue_valid, xif_issue_instr, xif_issue_id, xif_issue_rs, xif_issue_rs_valid,
    output xif_issue_ready, xif_issue_accept, xif_issue_writeback,
    input  xif_commit_valid, xif_commit_id, xif_commit_kill,
    output xif_result_valid, xif_result_id, xif_result_data, xif_result_rd, xif_result_we,
    input  xif_result_ready
  );
endinterface

// File: rtl/xif_coproc_alu_frontend.sv
// Coprocessor endpoint for offloaded custom-0 ALU instructions.
// Handshakes: issue completes on valid&ready (accept/writeback only meaningful then);
// a result is transferred on result_valid&result_ready and is held stable otherwise.
// Accepted instructions wait in an in-order queue until committed or killed; the head
// is retired one per cycle, producing a result only when committed and not killed.
module xif_coproc_alu_frontend #(
  parameter int X_ID_WIDTH = 4,
  parameter int X_NUM_RS   = 2,
  parameter int DEPTH      = 4
) (
  input  logic clk,
  input  logic rst_n,
  xif_coproc_alu_frontend_if.slave xif
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef struct packed {
    logic [X_ID_WIDTH-1:0] id;
    logic [2:0]            funct3;
    logic [4:0]            rd;
    logic [31:0]           rs1;
    logic [31:0]           rs2;
    logic                  committed;
    logic                  killed;
  } entry_t;

  entry_t                q [DEPTH];
  logic [DEPTH-1:0]      q_valid;
  logic [PW-1:0]         wptr, rptr;
  logic [CW-1:0]         count;

  logic                  decode_ok, issue_ready, push, pop, pop_exec;
  logic [DEPTH-1:0]      commit_hit;
  entry_t                head;
  logic                  head_committed, head_killed, out_free;
  logic [31:0]           alu_result;

  logic                  res_valid, res_we;
  logic [X_ID_WIDTH-1:0] res_id;
  logic [31:0]           res_data;
  logic [4:0]            res_rd;

  // rs1/rs2 register-index fields travel as operand values, so their bits are not needed here
  logic                  unused_instr_bits;
  assign unused_instr_bits = ^xif.xif_issue_instr[24:15];

  // Decode custom-0 ALU ops and form the issue handshake from the registered count
  always_comb begin
    decode_ok = 1'b0;
    if (xif.xif_issue_instr[6:0] == 7'b0001011 && xif.xif_issue_instr[31:25] == 7'd0) begin
      case (xif.xif_issue_instr[14:12])
        3'b000, 3'b001, 3'b100, 3'b110, 3'b111: decode_ok = 1'b1;
        default:                                decode_ok = 1'b0;
      endcase
    end
    issue_ready = rst_n && (count < CW'(DEPTH)) && (xif.xif_issue_rs_valid[1:0] == 2'b11);
    push        = xif.xif_issue_valid && issue_ready && decode_ok;
  end

  assign xif.xif_issue_ready     = issue_ready;
  assign xif.xif_issue_accept    = push;
  assign xif.xif_issue_writeback = push;

  // Commit CAM over outstanding entries, plus head retire decision with commit bypass
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      commit_hit[i] = xif.xif_commit_valid && q_valid[i] && (q[i].id == xif.xif_commit_id);
    end
    head           = q[rptr];
    head_killed    = head.killed || (commit_hit[rptr] && xif.xif_commit_kill);
    head_committed = head.committed || (commit_hit[rptr] && !xif.xif_commit_kill);
    out_free       = !res_valid || xif.xif_result_ready;
    pop_exec       = q_valid[rptr] && head_committed && !head_killed && out_free;
    pop            = (q_valid[rptr] && head_killed) || pop_exec;
  end

  // 32-bit modulo ALU on the head entry
  always_comb begin
    alu_result = 32'd0;
    case (head.funct3)
      3'b000:  alu_result = head.rs1 + head.rs2;
      3'b001:  alu_result = head.rs1 - head.rs2;
      3'b100:  alu_result = head.rs1 ^ head.rs2;
      3'b110:  alu_result = head.rs1 | head.rs2;
      3'b111:  alu_result = head.rs1 & head.rs2;
      default: alu_result = 32'd0;
    endcase
  end

  // Queue storage: mark commits/kills, retire the head, append accepted issues
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) q[i] <= '0;
      q_valid <= '0;
      wptr    <= '0;
      rptr    <= '0;
      count   <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (commit_hit[i]) begin
          if (xif.xif_commit_kill) q[i].killed    <= 1'b1;
          else                     q[i].committed <= 1'b1;
        end
      end
      if (pop) begin
        q_valid[rptr] <= 1'b0;
        rptr          <= rptr + PW'(1);
      end
      if (push) begin
        q[wptr] <= '{id:        xif.xif_issue_id,
                     funct3:    xif.xif_issue_instr[14:12],
                     rd:        xif.xif_issue_instr[11:7],
                     rs1:       xif.xif_issue_rs[31:0],
                     rs2:       xif.xif_issue_rs[63:32],
                     committed: 1'b0,
                     killed:    1'b0};
        q_valid[wptr] <= 1'b1;
        wptr          <= wptr + PW'(1);
      end
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // Result register: load on retire, drop on consume, otherwise hold
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_valid <= 1'b0;
      res_id    <= '0;
      res_data  <= '0;
      res_rd    <= '0;
      res_we    <= 1'b0;
    end else if (pop_exec) begin
      res_valid <= 1'b1;
      res_id    <= head.id;
      res_data  <= alu_result;
      res_rd    <= head.rd;
      res_we    <= (head.rd != 5'd0);
    end else if (xif.xif_result_ready) begin
      res_valid <= 1'b0;
    end
  end

  assign xif.xif_result_valid = res_valid;
  assign xif.xif_result_id    = res_id;
  assign xif.xif_result_data  = res_data;
  assign xif.xif_result_rd    = res_rd;
  assign xif.xif_result_we    = res_we;

  // The core must not commit an id in the same cycle it is being issued
  commit_with_issue_same_id: assert property (@(posedge clk) disable iff (!rst_n)
    !(push && xif.xif_commit_valid && (xif.xif_commit_id == xif.xif_issue_id)));
endmodule
